// File: rtl/audio_mixer_seq.sv
// Time-multiplexed N-channel audio mixer: snapshots all channels on a strobe,
// accumulates one attenuated channel per clock, then saturates to the output width.
module audio_mixer_seq #(
  parameter int NUM_CH      = 4,
  parameter int IN_W        = 16,
  parameter int OUT_W       = 16,
  parameter int GAIN_W      = 4,
  parameter int UNSIGNED_IN = 0
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       sample_stb,
  input  logic [NUM_CH*IN_W-1:0]     ch_data,
  input  logic [NUM_CH-1:0]          ch_enable,
  input  logic [NUM_CH*GAIN_W-1:0]   ch_gain,
  input  logic                       clip_clr,
  output logic [OUT_W-1:0]           audio_out,
  output logic [OUT_W-1:0]           audio_out_u,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       clip,
  output logic                       overrun,
  output logic [1:0]                 dbg_state
);

  // Handshake: sample_stb is a one-cycle request accepted only in IDLE (no ready
  // signal; a strobe seen while busy is dropped and flagged in overrun). out_valid
  // is a one-cycle pulse marking the edge on which audio_out/audio_out_u update.

  localparam int CH_LOG = $clog2(NUM_CH);
  localparam int IDX_W  = (NUM_CH > 1) ? CH_LOG : 1;
  localparam int ACC_W  = IN_W + CH_LOG + 1;
  localparam int SHIFT  = OUT_W - IN_W;
  localparam int SC_W   = ACC_W + SHIFT;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [IN_W-1:0]  MSB_FLIP = (UNSIGNED_IN != 0) ? {1'b1, {(IN_W-1){1'b0}}} : '0;
  localparam logic [OUT_W-1:0] OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_SAT  = 2'd2
  } state_t;

  state_t                     r_state;
  logic [NUM_CH*IN_W-1:0]     r_snap_data;
  logic [NUM_CH-1:0]          r_snap_en;
  logic [NUM_CH*GAIN_W-1:0]   r_snap_gain;
  logic signed [ACC_W-1:0]    r_acc;
  logic [IDX_W-1:0]           r_idx;
  logic [OUT_W-1:0]           r_audio;
  logic [OUT_W-1:0]           r_audio_u;
  logic                       r_valid;
  logic                       r_busy;
  logic                       r_clip;
  logic                       r_overrun;

  logic [IN_W-1:0]            w_raw;
  logic signed [IN_W-1:0]     w_x;
  logic signed [IN_W-1:0]     w_shifted;
  logic [GAIN_W-1:0]          w_gain;
  logic                       w_en;
  logic signed [ACC_W-1:0]    w_term;
  logic signed [ACC_W-1:0]    w_acc_next;
  logic signed [SC_W-1:0]     w_scaled;
  logic [SC_W-OUT_W:0]        w_hi;
  logic                       w_sat;
  logic [OUT_W-1:0]           w_result;

  // Current channel term; a signed >>> by any amount floors, so gains at or
  // beyond IN_W naturally collapse to 0 or -1.
  always_comb begin
    w_raw      = r_snap_data[r_idx*IN_W +: IN_W];
    w_gain     = r_snap_gain[r_idx*GAIN_W +: GAIN_W];
    w_en       = r_snap_en[r_idx];
    w_x        = $signed(w_raw ^ MSB_FLIP);
    w_shifted  = w_x >>> w_gain;
    w_term     = w_en ? {{(ACC_W-IN_W){w_shifted[IN_W-1]}}, w_shifted} : '0;
    w_acc_next = r_acc + w_term;
  end

  // Scale up to the output width; the result fits only if every bit above the
  // output sign bit matches it.
  always_comb begin
    w_scaled = SC_W'(r_acc) <<< SHIFT;
    w_hi     = w_scaled[SC_W-1:OUT_W-1];
    w_sat    = !((&w_hi) || !(|w_hi));
    w_result = w_sat ? (w_hi[SC_W-OUT_W] ? OUT_MIN : OUT_MAX) : w_scaled[OUT_W-1:0];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_snap_data <= '0;
      r_snap_en   <= '0;
      r_snap_gain <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_audio     <= '0;
      r_audio_u   <= OUT_MIN;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_clip      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (clip_clr) begin
        r_clip    <= 1'b0;
        r_overrun <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (sample_stb) begin
            r_snap_data <= ch_data;
            r_snap_en   <= ch_enable;
            r_snap_gain <= ch_gain;
            r_acc       <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b1;
            r_state     <= ST_ACC;
          end
        end
        ST_ACC: begin
          r_acc <= w_acc_next;
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= ST_SAT;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_SAT: begin
          r_audio   <= w_result;
          r_audio_u <= w_result ^ OUT_MIN;
          r_valid   <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
          if (w_sat) r_clip <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
      // Placed after the clear so a same-edge event keeps the flag set.
      if (sample_stb && (r_state != ST_IDLE)) r_overrun <= 1'b1;
    end
  end

  assign audio_out   = r_audio;
  assign audio_out_u = r_audio_u;
  assign out_valid   = r_valid;
  assign busy        = r_busy;
  assign clip        = r_clip;
  assign overrun     = r_overrun;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_audio_mixer_seq.sv
// Directed and randomized bench for audio_mixer_seq: signed and offset-binary
// instances, results checked through expected-value queues.
module tb_audio_mixer_seq;

  logic        clk;
  logic        reset;
  logic        stb_s;
  logic        stb_u;
  logic [63:0] ch_data;
  logic [3:0]  ch_enable;
  logic [15:0] ch_gain;
  logic        clip_clr;

  logic [15:0] ao_s, aou_s, ao_u, aou_u;
  logic        ov_s, busy_s, clip_s, orun_s;
  logic        ov_u, busy_u, clip_u, orun_u;
  logic [1:0]  st_s, st_u;

  logic [15:0] exp_q[$];
  logic [15:0] exp_u_q[$];
  int          errors = 0;
  int          checks = 0;
  int          valid_cnt_s = 0;
  int          valid_cnt_u = 0;

  audio_mixer_seq #(.NUM_CH(4), .IN_W(16), .OUT_W(16), .GAIN_W(4), .UNSIGNED_IN(0)) u_dut_s (
    .clk_sys(clk), .reset(reset), .sample_stb(stb_s), .ch_data(ch_data),
    .ch_enable(ch_enable), .ch_gain(ch_gain), .clip_clr(clip_clr),
    .audio_out(ao_s), .audio_out_u(aou_s), .out_valid(ov_s), .busy(busy_s),
    .clip(clip_s), .overrun(orun_s), .dbg_state(st_s)
  );

  audio_mixer_seq #(.NUM_CH(4), .IN_W(16), .OUT_W(16), .GAIN_W(4), .UNSIGNED_IN(1)) u_dut_u (
    .clk_sys(clk), .reset(reset), .sample_stb(stb_u), .ch_data(ch_data),
    .ch_enable(ch_enable), .ch_gain(ch_gain), .clip_clr(clip_clr),
    .audio_out(ao_u), .audio_out_u(aou_u), .out_valid(ov_u), .busy(busy_u),
    .clip(clip_u), .overrun(orun_u), .dbg_state(st_u)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer sum of floored shifts, clamped to 16-bit signed.
  function automatic logic [16:0] model(input logic [63:0] d, input logic [3:0] en,
                                        input logic [15:0] g, input bit uns);
    int          sum;
    int          x;
    logic [15:0] v;
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      v = d[k*16 +: 16];
      if (uns) v[15] = ~v[15];
      x = int'($signed(v));
      if (en[k]) sum += x >>> g[k*4 +: 4];
    end
    if (sum > 32767)       return {1'b1, 16'h7FFF};
    else if (sum < -32768) return {1'b1, 16'h8000};
    else                   return {1'b0, sum[15:0]};
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (ov_s) begin
      valid_cnt_s++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_s_unexpected: observed out_valid with audio_out=%0h, expected no output", ao_s);
      end
      if (exp_q.size() > 0) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("sb_s_audio_out", ao_s, e);
        check("sb_s_audio_out_u", aou_s, e ^ 16'h8000);
      end
    end
    if (ov_u) begin
      valid_cnt_u++;
      checks++;
      assert (exp_u_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_u_unexpected: observed out_valid with audio_out=%0h, expected no output", ao_u);
      end
      if (exp_u_q.size() > 0) begin
        logic [15:0] e;
        e = exp_u_q.pop_front();
        check("sb_u_audio_out", ao_u, e);
        check("sb_u_audio_out_u", aou_u, e ^ 16'h8000);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_s(input logic [63:0] d, input logic [3:0] en, input logic [15:0] g);
    logic [16:0] m;
    ch_data = d; ch_enable = en; ch_gain = g; stb_s = 1'b1;
    m = model(d, en, g, 1'b0);
    exp_q.push_back(m[15:0]);
    step();
    stb_s = 1'b0;
  endtask

  task automatic start_u(input logic [63:0] d, input logic [3:0] en, input logic [15:0] g);
    logic [16:0] m;
    ch_data = d; ch_enable = en; ch_gain = g; stb_u = 1'b1;
    m = model(d, en, g, 1'b1);
    exp_u_q.push_back(m[15:0]);
    step();
    stb_u = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input bit use_u);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      step();
      n++;
      seen = use_u ? ov_u : ov_s;
    end
    checks++;
    assert (seen) else begin
      errors++;
      $error("FAIL %s: out_valid not seen after %0d cycles, expected within 20", tag, n);
    end
  endtask

  initial begin
    int          edges;
    int          busy_cnt;
    int          vc;
    logic [63:0] rd;
    logic [3:0]  re;
    logic [15:0] rg;
    logic [16:0] rm;

    reset = 1'b1; stb_s = 1'b0; stb_u = 1'b0; clip_clr = 1'b0;
    ch_data = '0; ch_enable = '0; ch_gain = '0;
    step(); step();
    check("rst_audio_out", ao_s, 16'h0000);
    check("rst_audio_out_u", aou_s, 16'h8000);
    check("rst_out_valid", ov_s, 1'b0);
    check("rst_busy", busy_s, 1'b0);
    check("rst_clip", clip_s, 1'b0);
    check("rst_overrun", orun_s, 1'b0);
    check("rst_state", st_s, 2'd0);
    reset = 1'b0;
    step();

    // 1: basic mix, latency and busy length
    start_s(64'h0000_FE0C_07D0_03E8, 4'b1111, 16'h0000);
    busy_cnt = (busy_s === 1'b1) ? 1 : 0;
    edges = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (busy_s === 1'b1) busy_cnt++;
      if (ov_s === 1'b1) begin
        edges = e;
        break;
      end
    end
    check("t1_latency", edges, 5);
    check("t1_busy_cycles", busy_cnt, 5);
    check("t1_audio_out", ao_s, 16'h09C4);
    check("t1_audio_out_u", aou_s, 16'h89C4);
    check("t1_clip", clip_s, 1'b0);
    step();
    check("t1_valid_one_cycle", ov_s, 1'b0);
    check("t1_hold", ao_s, 16'h09C4);

    // 2: positive and negative saturation, then clear
    start_s(64'h7000_7000_7000_7000, 4'b1111, 16'h0000);
    wait_valid("t2_pos_valid", 1'b0);
    check("t2_pos_value", ao_s, 16'h7FFF);
    check("t2_pos_clip", clip_s, 1'b1);
    step();
    start_s(64'h9000_9000_9000_9000, 4'b1111, 16'h0000);
    wait_valid("t2_neg_valid", 1'b0);
    check("t2_neg_value", ao_s, 16'h8000);
    clip_clr = 1'b1;
    step();
    clip_clr = 1'b0;
    check("t2_clip_cleared", clip_s, 1'b0);

    // 3: gains and enables
    start_s(64'h7FFF_7FFF_FFFD_4000, 4'b0011, 16'h0012);
    wait_valid("t3_valid", 1'b0);
    check("t3_value", ao_s, 16'h0FFE);
    step();

    // 4: overrun strobe with inputs changed after acceptance
    start_s(64'h0001_0002_0003_0004, 4'b1111, 16'h0000);
    ch_data = 64'h1111_2222_3333_4444;
    check("t4_overrun_before", orun_s, 1'b0);
    vc = valid_cnt_s;
    step();
    stb_s = 1'b1;
    step();
    stb_s = 1'b0;
    check("t4_overrun_set", orun_s, 1'b1);
    wait_valid("t4_valid", 1'b0);
    check("t4_value", ao_s, 16'h000A);
    repeat (12) step();
    check("t4_single_valid", valid_cnt_s - vc, 1);

    // 5: reset during accumulation aborts the mix
    start_s(64'h0100_0100_0100_0100, 4'b1111, 16'h0000);
    step(); step();
    check("t5_in_acc", st_s, 2'd1);
    reset = 1'b1;
    void'(exp_q.pop_back());
    #1;
    check("t5_rst_audio_out", ao_s, 16'h0000);
    check("t5_rst_audio_out_u", aou_s, 16'h8000);
    check("t5_rst_busy", busy_s, 1'b0);
    check("t5_rst_overrun", orun_s, 1'b0);
    check("t5_rst_valid", ov_s, 1'b0);
    check("t5_rst_state", st_s, 2'd0);
    vc = valid_cnt_s;
    step();
    reset = 1'b0;
    repeat (10) step();
    check("t5_no_valid", valid_cnt_s - vc, 0);
    start_s(64'h0001_0001_0001_0001, 4'b1111, 16'h0000);
    wait_valid("t5_after_valid", 1'b0);
    check("t5_after_value", ao_s, 16'h0004);
    step();

    // 6: offset-binary inputs
    start_u(64'h8000_8000_8000_8000, 4'b1111, 16'h0000);
    wait_valid("t6_mid_valid", 1'b1);
    check("t6_mid_value", ao_u, 16'h0000);
    check("t6_mid_clip", clip_u, 1'b0);
    step();
    start_u(64'hFFFF_FFFF_FFFF_FFFF, 4'b1111, 16'h0000);
    wait_valid("t6_max_valid", 1'b1);
    check("t6_max_value", ao_u, 16'h7FFF);
    check("t6_max_clip", clip_u, 1'b1);
    step();

    // random mixes, clip flag cleared on the accepting edge
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) begin
        rd[k*16 +: 16] = 16'($urandom_range(0, 65535));
        rg[k*4 +: 4]   = 4'($urandom_range(0, 15));
      end
      re = 4'($urandom_range(0, 15));
      rm = model(rd, re, rg, 1'b0);
      clip_clr = 1'b1;
      start_s(rd, re, rg);
      clip_clr = 1'b0;
      wait_valid("rnd_valid", 1'b0);
      check("rnd_clip", clip_s, rm[16]);
      repeat ($urandom_range(1, 3)) step();
    end

    step();
    check("sb_s_drained", exp_q.size(), 0);
    check("sb_u_drained", exp_u_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_mixer_seq.md
Name: audio_mixer_seq

Overview:
- Parametrised, time-multiplexed N-channel audio mixer. Replaces the ad-hoc combinational summing of tape, core PSG, buzzer and relay sources ahead of the dac/i2s/spdif outputs.
- Snapshots all channels on a sample strobe, then accumulates one channel per clock with per-channel enable and shift attenuation.
- Saturates the sum to the output width and reports clipping and strobe overrun.

Parameters:
NUM_CH, 4, number of input channels (>=1)
IN_W, 16, per-channel sample width
OUT_W, 16, output width (must be >= IN_W)
GAIN_W, 4, per-channel attenuation field width (right-shift amount)
UNSIGNED_IN, 0, 1 = inputs are offset-binary and converted to signed by inverting the MSB

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
sample_stb  in  1  one-cycle pulse requesting a new mix
ch_data  in  NUM_CH*IN_W  channel samples; channel k occupies bits [k*IN_W +: IN_W]
ch_enable  in  NUM_CH  per-channel enable
ch_gain  in  NUM_CH*GAIN_W  per-channel arithmetic right-shift amount
clip_clr  in  1  clears the sticky clip and overrun flags
audio_out  out  OUT_W  signed mixed sample
audio_out_u  out  OUT_W  audio_out with MSB inverted (offset binary, for the dac)
out_valid  out  1  one-cycle pulse when audio_out updates
busy  out  1  high while a mix is in progress
clip  out  1  sticky: a result saturated
overrun  out  1  sticky: sample_stb arrived while not IDLE

Behaviour:
- Reset: asynchronous, active-high.
  - audio_out = 0, audio_out_u = 2^(OUT_W-1), out_valid = busy = clip = overrun = 0.
  - State = IDLE; accumulator, index and snapshot registers = 0.
  - Reset asserted mid-mix aborts the mix immediately; no out_valid is produced for it.
- States: IDLE, ACC, SAT.
- IDLE: on an edge with sample_stb = 1:
  - snapshot ch_data, ch_enable and ch_gain;
  - acc = 0, idx = 0, go to ACC, busy = 1.
- ACC: each edge does acc += term(idx) and idx += 1. After adding idx = NUM_CH-1, go to SAT.
- term(k):
  - x = snapshot sample, MSB inverted if UNSIGNED_IN;
  - term = enable[k] ? (x >>> gain[k]) : 0, arithmetic shift (floor);
  - a gain >= IN_W yields 0 for x >= 0 and -1 for x < 0.
- Accumulator: signed, width IN_W + clog2(NUM_CH) + 1. It never overflows internally.
- SAT:
  - r = acc * 2^(OUT_W-IN_W), clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1];
  - audio_out and audio_out_u register r, out_valid = 1 for one cycle;
  - clip set if clamping occurred;
  - state returns to IDLE, busy = 0 on the same edge.
- Latency: out_valid is high in the cycle after edge E0+NUM_CH+1, where E0 is the edge that accepted sample_stb. Minimum strobe spacing is NUM_CH+2 cycles.
- sample_stb sampled high in ACC or SAT is ignored: overrun = 1, current mix unaffected.
- Inputs changing after acceptance do not affect the current result.
- audio_out holds its value between out_valid pulses.
- clip_clr clears clip and overrun. If clip_clr and a new clip/overrun event occur on the same edge, the set wins.

Test Plan (NUM_CH=4, IN_W=OUT_W=16, GAIN_W=4 unless stated):
1. ch = {1000, 2000, -500, 0}, gains 0, enable 4'b1111, single sample_stb -> out_valid exactly 5 edges after acceptance; audio_out = 2500 (0x09C4), audio_out_u = 0x89C4; clip = 0; busy high for 5 cycles.
2. All ch = 0x7000 -> audio_out = 0x7FFF, clip = 1. Then all ch = 0x9000 -> audio_out = 0x8000. Then clip_clr -> clip = 0.
3. ch0 = 0x4000 with gain 2, ch1 = -3 with gain 1, ch2 = ch3 = 0x7FFF, enable 4'b0011 -> audio_out = 0x0FFE (0x1000 + -2).
4. Second sample_stb 2 cycles after the first, with ch_data changed right after acceptance -> overrun = 1, exactly one out_valid, result computed from the first snapshot only.
5. reset pulsed during ACC (idx = 2) -> all outputs return to reset values asynchronously, no out_valid. A following stb with ch = {1, 1, 1, 1} yields 4.
6. UNSIGNED_IN = 1 instance, all ch = 0x8000 -> audio_out = 0. All ch = 0xFFFF -> 4 × 0x7FFF saturates to 0x7FFF, clip = 1.
